// File: rtl/carrier_pkg.sv
// Shared types and constants for the IR carrier PWM block.
package carrier_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FORCED = 2'd1,
    S_HIGH   = 2'd2,
    S_LOW    = 2'd3
  } state_e;

  localparam int NUM_STATES       = 4;
  localparam int DEFAULT_PWM_BITS = 8;

endpackage

// File: rtl/tick_divider.sv
// Prescaler: one-clock tick every PRESCALE enabled clocks, restartable via clear.
module tick_divider #(
  parameter int PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick_o = enable_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/carrier_pwm.sv
// IR carrier generator: 50 % duty carrier of half-period (value+1)*PRESCALE clocks,
// with forced-on override and glitch-free period updates.
module carrier_pwm
  import carrier_pkg::*;
#(
  parameter int PWM_BITS = DEFAULT_PWM_BITS,
  parameter int PRESCALE = 1
) (
  input  logic                clock_in,
  input  logic                reset_n_in,
  input  logic                pwm_enable_in,
  input  logic                pwm_forced_in,
  input  logic                pwm_wr_strobe_in,
  input  logic [PWM_BITS-1:0] pwm_value_in,
  output logic                pwm_wr_ack_out,
  output logic                carrier_out,
  output logic                active_out
);

  // Write handshake: a write is the rising edge of pwm_wr_strobe_in; the value is
  // captured at that clock edge and pwm_wr_ack_out pulses high for the following cycle.
  state_e              state_q, state_d;
  logic                carrier_q, carrier_d;
  logic                ack_q, ack_d;
  logic                strobe_q;
  logic [PWM_BITS-1:0] act_q, act_d;
  logic [PWM_BITS-1:0] pend_q, pend_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                running, wr, tick, phase_done;

  assign running    = (state_q == S_HIGH) || (state_q == S_LOW);
  assign wr         = pwm_wr_strobe_in && !strobe_q;
  assign phase_done = tick && (cnt_q == act_q);

  tick_divider #(.PRESCALE(PRESCALE)) u_div (
    .clk_i    (clock_in),
    .rst_ni   (reset_n_in),
    .clear_i  (!running),
    .enable_i (running),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    pend_d  = wr ? pwm_value_in : pend_q;
    ack_d   = wr;
    if (!running) act_d = pend_q;

    if (pwm_forced_in)       state_d = S_FORCED;
    else if (!pwm_enable_in) state_d = S_IDLE;
    else if (!running)       state_d = S_HIGH;
    else if (phase_done)     state_d = (state_q == S_HIGH) ? S_LOW : S_HIGH;

    // The new value takes effect only at a period boundary, never mid-period.
    if (state_q == S_LOW && state_d == S_HIGH) act_d = pend_q;

    if (!running || state_d != state_q) cnt_d = '0;
    else if (tick && cnt_q != act_q)    cnt_d = cnt_q + PWM_BITS'(1);

    carrier_d = (state_d == S_HIGH) || (state_d == S_FORCED);
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= S_IDLE;
      carrier_q <= 1'b0;
      ack_q     <= 1'b0;
      strobe_q  <= 1'b0;
      act_q     <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      carrier_q <= carrier_d;
      ack_q     <= ack_d;
      strobe_q  <= pwm_wr_strobe_in;
      act_q     <= act_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign carrier_out    = carrier_q;
  assign pwm_wr_ack_out = ack_q;
  assign active_out     = (state_q != S_IDLE);

endmodule
